// File: rtl/writeback_unit_pkg.sv
// Shared codes for the writeback stage: result sources, load sizes, FSM states
// and the payload captured when an instruction is accepted.
package writeback_unit_pkg;

    localparam logic [1:0] WB_SRC_ALU = 2'b00;
    localparam logic [1:0] WB_SRC_MEM = 2'b01;
    localparam logic [1:0] WB_SRC_PC4 = 2'b10;

    localparam logic [1:0] LD_BYTE = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_COMMIT    = 2'b01,
        ST_WAIT_LOAD = 2'b10
    } wb_state_e;

    // Fields needed after accept: destination plus how to shape the load data.
    typedef struct packed {
        logic       reg_write;
        logic [4:0] write_register;
        logic [1:0] load_size;
        logic       load_unsigned;
        logic [1:0] addr_low;
    } hold_t;

    // x0 is hardwired, so a write aimed at it is dropped.
    function automatic logic commit_enable(input logic reg_write, input logic [4:0] rd);
        return reg_write && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/writeback_unit_load_extender.sv
// Combinational load lane selection and sign/zero extension of a raw
// little-endian memory word.
module writeback_unit_load_extender
    import writeback_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_low,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  byte_lane [4];
    logic [15:0] half_lane [2];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte
            assign byte_lane[gi] = rdata[8*gi +: 8];
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_half
            assign half_lane[gi] = rdata[16*gi +: 16];
        end
    endgenerate

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = byte_lane[addr_low];
    assign sel_half = half_lane[addr_low[1]];

    always_comb begin
        result = rdata;
        case (size)
            LD_BYTE: result = {{24{~is_unsigned & sel_byte[7]}}, sel_byte};
            LD_HALF: result = {{16{~is_unsigned & sel_half[15]}}, sel_half};
            LD_WORD: result = rdata;
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: accepts retiring instructions, waits for load data with a
// timeout, and drives a registered single-cycle register-file write.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_RegWrite,
    input  logic [4:0]       in_Write_register,
    input  logic [1:0]       in_MemtoReg,
    input  logic [31:0]      in_ALU_out,
    input  logic [31:0]      in_PC_plus4,
    input  logic [1:0]       in_load_size,
    input  logic             in_load_unsigned,
    input  logic [1:0]       in_addr_low,
    input  logic             rdata_valid,
    input  logic [31:0]      rdata,
    output logic             RegWrite,
    output logic [4:0]       Write_register,
    output logic [31:0]      Write_data,
    output logic             wb_stall,
    output logic             load_timeout,
    output logic [CNT_W-1:0] retire_count
);

    localparam int TW = (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT);

    wb_state_e        state_reg, state_next;
    hold_t            hold_reg, hold_next;
    logic [TW-1:0]    tcnt_reg, tcnt_next;
    logic             reg_write_reg;
    logic [4:0]       write_register_reg;
    logic [31:0]      write_data_reg;
    logic             load_timeout_reg;
    logic [CNT_W-1:0] retire_reg;

    logic             accept;
    logic             in_is_load;
    logic [31:0]      ext_data;
    logic             commit_next;
    logic             commit_rw_next;
    logic [4:0]       commit_rd_next;
    logic [31:0]      commit_data_next;
    logic             commit_we_next;
    logic             timeout_next;

    assign in_ready   = (state_reg != ST_WAIT_LOAD);
    assign accept     = in_valid && in_ready;
    assign in_is_load = (in_MemtoReg == WB_SRC_MEM);

    writeback_unit_load_extender u_load_extender (
        .rdata       (rdata),
        .addr_low    (hold_reg.addr_low),
        .size        (hold_reg.load_size),
        .is_unsigned (hold_reg.load_unsigned),
        .result      (ext_data)
    );

    always_comb begin
        state_next       = state_reg;
        hold_next        = hold_reg;
        tcnt_next        = '0;
        commit_next      = 1'b0;
        commit_rw_next   = 1'b0;
        commit_rd_next   = 5'd0;
        commit_data_next = 32'd0;
        timeout_next     = 1'b0;

        case (state_reg)
            ST_IDLE, ST_COMMIT: begin
                if (accept) begin
                    hold_next.reg_write      = in_RegWrite;
                    hold_next.write_register = in_Write_register;
                    hold_next.load_size      = in_load_size;
                    hold_next.load_unsigned  = in_load_unsigned;
                    hold_next.addr_low       = in_addr_low;
                    if (in_is_load) begin
                        state_next = ST_WAIT_LOAD;
                    end else begin
                        state_next     = ST_COMMIT;
                        commit_next    = 1'b1;
                        commit_rw_next = in_RegWrite;
                        commit_rd_next = in_Write_register;
                        case (in_MemtoReg)
                            WB_SRC_ALU: commit_data_next = in_ALU_out;
                            WB_SRC_PC4: commit_data_next = in_PC_plus4;
                            default:    commit_data_next = in_ALU_out;
                        endcase
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_LOAD: begin
                // Data arriving in the final allowed cycle still wins over the timeout.
                if (rdata_valid) begin
                    state_next       = ST_COMMIT;
                    commit_next      = 1'b1;
                    commit_rw_next   = hold_reg.reg_write;
                    commit_rd_next   = hold_reg.write_register;
                    commit_data_next = ext_data;
                end else if (tcnt_reg == TW'(LOAD_TIMEOUT - 1)) begin
                    state_next   = ST_COMMIT;
                    commit_next  = 1'b1;
                    timeout_next = 1'b1;
                end else begin
                    tcnt_next = tcnt_reg + TW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase

        commit_we_next = commit_next && commit_enable(commit_rw_next, commit_rd_next);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= ST_IDLE;
            hold_reg           <= '0;
            tcnt_reg           <= '0;
            reg_write_reg      <= 1'b0;
            write_register_reg <= 5'd0;
            write_data_reg     <= 32'd0;
            load_timeout_reg   <= 1'b0;
            retire_reg         <= '0;
        end else begin
            state_reg          <= state_next;
            hold_reg           <= hold_next;
            tcnt_reg           <= tcnt_next;
            // The register file bypasses on address alone, so an idle port reads 0/0.
            reg_write_reg      <= commit_we_next;
            write_register_reg <= commit_we_next ? commit_rd_next : 5'd0;
            write_data_reg     <= commit_we_next ? commit_data_next : 32'd0;
            load_timeout_reg   <= timeout_next;
            if (commit_next) begin
                retire_reg <= retire_reg + CNT_W'(1);
            end
        end
    end

    assign RegWrite       = reg_write_reg;
    assign Write_register = write_register_reg;
    assign Write_data     = write_data_reg;
    assign wb_stall       = (state_reg == ST_WAIT_LOAD);
    assign load_timeout   = load_timeout_reg;
    assign retire_count   = retire_reg;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus a randomized
// instruction stream checked against a behavioural model of the commit rules.
module tb_writeback_unit;

    localparam int LT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_RegWrite = 1'b0;
    logic [4:0]  in_Write_register = 5'd0;
    logic [1:0]  in_MemtoReg = 2'd0;
    logic [31:0] in_ALU_out = 32'd0;
    logic [31:0] in_PC_plus4 = 32'd0;
    logic [1:0]  in_load_size = 2'd0;
    logic        in_load_unsigned = 1'b0;
    logic [1:0]  in_addr_low = 2'd0;
    logic        rdata_valid = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic        RegWrite;
    logic [4:0]  Write_register;
    logic [31:0] Write_data;
    logic        wb_stall;
    logic        load_timeout;
    logic [31:0] retire_count;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_retire = 32'd0;

    writeback_unit #(.LOAD_TIMEOUT(LT), .CNT_W(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_RegWrite       (in_RegWrite),
        .in_Write_register (in_Write_register),
        .in_MemtoReg       (in_MemtoReg),
        .in_ALU_out        (in_ALU_out),
        .in_PC_plus4       (in_PC_plus4),
        .in_load_size      (in_load_size),
        .in_load_unsigned  (in_load_unsigned),
        .in_addr_low       (in_addr_low),
        .rdata_valid       (rdata_valid),
        .rdata             (rdata),
        .RegWrite          (RegWrite),
        .Write_register    (Write_register),
        .Write_data        (Write_data),
        .wb_stall          (wb_stall),
        .load_timeout      (load_timeout),
        .retire_count      (retire_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference load shaping: shift the addressed lane down, mask to size, extend.
    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] addr,
                                               input logic [1:0] size, input logic uns);
        int nbytes;
        int off;
        logic [31:0] v;
        logic [31:0] mask;
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off    = (nbytes == 1) ? int'(addr) : (nbytes == 2) ? (int'(addr) & 2) : 0;
        v      = word >> (8 * off);
        if (nbytes < 4) begin
            mask = (32'd1 << (8 * nbytes)) - 32'd1;
            v    = v & mask;
            if (!uns && v[8*nbytes-1]) v = v | ~mask;
        end
        return v;
    endfunction

    // delay = WAIT_LOAD cycle (1-based) carrying rdata_valid; delay > LT means none.
    task automatic model_expect(input logic rw, input logic [4:0] rd, input logic [1:0] src,
                                input logic [31:0] alu, input logic [31:0] pc4,
                                input logic [1:0] size, input logic uns, input logic [1:0] addr,
                                input logic [31:0] word, input int delay,
                                output logic e_we, output logic [4:0] e_rd,
                                output logic [31:0] e_data, output logic e_to);
        logic is_load;
        is_load = (src == 2'b01);
        e_to    = is_load && (delay > LT);
        e_we    = rw && (rd != 5'd0) && !e_to;
        e_rd    = e_we ? rd : 5'd0;
        if (!e_we)         e_data = 32'd0;
        else if (is_load)  e_data = model_load(word, addr, size, uns);
        else if (src == 2'b10) e_data = pc4;
        else               e_data = alu;
    endtask

    // Drives one instruction and returns what the write port shows in its commit cycle.
    task automatic issue(input logic rw, input logic [4:0] rd, input logic [1:0] src,
                         input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [1:0] size, input logic uns, input logic [1:0] addr,
                         input logic [31:0] word, input int delay, input logic noise,
                         output logic o_we, output logic [4:0] o_rd, output logic [31:0] o_data,
                         output logic o_to, output logic [31:0] o_retire, output logic o_ready,
                         output int wait_bad);
        wait_bad          = 0;
        in_valid          = 1'b1;
        in_RegWrite       = rw;
        in_Write_register = rd;
        in_MemtoReg       = src;
        in_ALU_out        = alu;
        in_PC_plus4       = pc4;
        in_load_size      = size;
        in_load_unsigned  = uns;
        in_addr_low       = addr;
        rdata_valid       = noise;
        rdata             = ~word;
        tick();
        in_valid    = 1'b0;
        rdata_valid = 1'b0;
        if (src == 2'b01) begin
            for (int cyc = 1; cyc <= LT; cyc++) begin
                if (wb_stall !== 1'b1 || in_ready !== 1'b0 || RegWrite !== 1'b0) wait_bad++;
                if (cyc == delay) begin
                    rdata_valid = 1'b1;
                    rdata       = word;
                end
                tick();
                rdata_valid = 1'b0;
                if (cyc == delay) break;
            end
        end
        o_we     = RegWrite;
        o_rd     = Write_register;
        o_data   = Write_data;
        o_to     = load_timeout;
        o_retire = retire_count;
        o_ready  = in_ready;
        exp_retire = exp_retire + 32'd1;
        $display("txn rw=%0b rd=%0d src=%0d delay=%0d -> we=%0b wr=%0d wd=%08h to=%0b ret=%0d",
                 rw, rd, src, delay, o_we, o_rd, o_data, o_to, o_retire);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b want=0", RegWrite); end
        total++; if (Write_register !== 5'd0) begin bad++; $display("FAIL reset_wr got=%0d want=0", Write_register); end
        total++; if (Write_data !== 32'd0) begin bad++; $display("FAIL reset_wd got=%08h want=0", Write_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", in_ready); end
        total++; if (wb_stall !== 1'b0 || load_timeout !== 1'b0) begin bad++; $display("FAIL reset_stall_to got=%0b%0b want=00", wb_stall, load_timeout); end
        total++; if (retire_count !== 32'd0) begin bad++; $display("FAIL reset_retire got=%0d want=0", retire_count); end
        reset      = 1'b0;
        exp_retire = 32'd0;
        $display("txn reset done");
    endtask

    task automatic test_alu_write();
        logic we, to, rdy; logic [4:0] wr; logic [31:0] wd, ret; int wb;
        issue(1'b1, 5'd5, 2'b00, 32'h1234, 32'h0, 2'd0, 1'b0, 2'd0, 32'h0, 0, 1'b0, we, wr, wd, to, ret, rdy, wb);
        total++; if (we !== 1'b1 || wr !== 5'd5 || wd !== 32'h1234) begin bad++; $display("FAIL alu_commit got=%0b/%0d/%08h want=1/5/00001234", we, wr, wd); end
        tick();
        total++; if (RegWrite !== 1'b0 || Write_register !== 5'd0 || Write_data !== 32'd0) begin bad++; $display("FAIL alu_idle got=%0b/%0d/%08h want=0/0/0", RegWrite, Write_register, Write_data); end
        total++; if (retire_count !== 32'd1) begin bad++; $display("FAIL alu_retire got=%0d want=1", retire_count); end
    endtask

    task automatic test_reg_zero();
        logic we, to, rdy; logic [4:0] wr; logic [31:0] wd, ret; int wb;
        issue(1'b1, 5'd0, 2'b00, 32'hFFFF, 32'h0, 2'd0, 1'b0, 2'd0, 32'h0, 0, 1'b0, we, wr, wd, to, ret, rdy, wb);
        total++; if (we !== 1'b0 || wr !== 5'd0 || wd !== 32'd0) begin bad++; $display("FAIL x0_commit got=%0b/%0d/%08h want=0/0/0", we, wr, wd); end
        total++; if (ret !== exp_retire) begin bad++; $display("FAIL x0_retire got=%0d want=%0d", ret, exp_retire); end
        tick();
    endtask

    task automatic test_byte_load();
        logic we, to, rdy; logic [4:0] wr; logic [31:0] wd, ret; int wb;
        issue(1'b1, 5'd8, 2'b01, 32'h0, 32'h0, 2'd0, 1'b0, 2'd2, 32'h12F03456, 3, 1'b1, we, wr, wd, to, ret, rdy, wb);
        total++; if (wb !== 0) begin bad++; $display("FAIL byte_wait_stall got=%0d bad cycles want=0", wb); end
        total++; if (we !== 1'b1 || wr !== 5'd8 || wd !== 32'hFFFFFFF0) begin bad++; $display("FAIL byte_commit got=%0b/%0d/%08h want=1/8/fffffff0", we, wr, wd); end
        total++; if (rdy !== 1'b1 || wb_stall !== 1'b0) begin bad++; $display("FAIL byte_release got=%0b/%0b want=1/0", rdy, wb_stall); end
        tick();
    endtask

    task automatic test_half_load();
        logic we, to, rdy; logic [4:0] wr; logic [31:0] wd, ret; int wb;
        issue(1'b1, 5'd9, 2'b01, 32'h0, 32'h0, 2'd1, 1'b1, 2'd2, 32'h8001ABCD, 1, 1'b0, we, wr, wd, to, ret, rdy, wb);
        total++; if (wd !== 32'h00008001) begin bad++; $display("FAIL half_unsigned got=%08h want=00008001", wd); end
        issue(1'b1, 5'd9, 2'b01, 32'h0, 32'h0, 2'd1, 1'b0, 2'd3, 32'h8001ABCD, 2, 1'b0, we, wr, wd, to, ret, rdy, wb);
        total++; if (wd !== 32'hFFFF8001) begin bad++; $display("FAIL half_signed got=%08h want=ffff8001", wd); end
        tick();
    endtask

    task automatic test_timeout();
        logic we, to, rdy; logic [4:0] wr; logic [31:0] wd, ret; int wb;
        issue(1'b1, 5'd12, 2'b01, 32'h0, 32'h0, 2'd2, 1'b0, 2'd0, 32'hDEADBEEF, LT + 1, 1'b0, we, wr, wd, to, ret, rdy, wb);
        total++; if (wb !== 0) begin bad++; $display("FAIL timeout_wait got=%0d bad cycles want=0", wb); end
        total++; if (to !== 1'b1 || we !== 1'b0 || wr !== 5'd0 || wd !== 32'd0) begin bad++; $display("FAIL timeout_commit got=%0b/%0b/%0d/%08h want=1/0/0/0", to, we, wr, wd); end
        total++; if (ret !== exp_retire || rdy !== 1'b1) begin bad++; $display("FAIL timeout_retire got=%0d/%0b want=%0d/1", ret, rdy, exp_retire); end
        rdata_valid = 1'b1;
        rdata       = 32'h00000077;
        tick();
        rdata_valid = 1'b0;
        total++; if (load_timeout !== 1'b0) begin bad++; $display("FAIL timeout_pulse got=%0b want=0", load_timeout); end
        tick();
        total++; if (RegWrite !== 1'b0 || Write_data !== 32'd0 || retire_count !== exp_retire) begin bad++; $display("FAIL late_rdata got=%0b/%08h/%0d want=0/0/%0d", RegWrite, Write_data, retire_count, exp_retire); end
    endtask

    task automatic test_back_to_back();
        logic we, to, rdy; logic [4:0] wr; logic [31:0] wd, ret; int wb;
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 5'(20 + i), (i == 1) ? 2'b10 : 2'b00, 32'hA000 + 32'(i), 32'hB000 + 32'(i),
                  2'd0, 1'b0, 2'd0, 32'h0, 0, 1'b0, we, wr, wd, to, ret, rdy, wb);
            total++;
            if (we !== 1'b1 || wr !== 5'(20 + i) || wd !== ((i == 1) ? 32'hB001 : 32'hA000 + 32'(i)) || ret !== exp_retire) begin
                bad++; $display("FAIL b2b_%0d got=%0b/%0d/%08h/%0d want rd=%0d ret=%0d", i, we, wr, wd, ret, 20 + i, exp_retire);
            end
        end
        tick();
    endtask

    task automatic test_random();
        logic we, to, rdy; logic [4:0] wr; logic [31:0] wd, ret; int wb;
        logic e_we, e_to; logic [4:0] e_rd; logic [31:0] e_data;
        logic rw, uns, noise; logic [4:0] rd; logic [1:0] src, size, addr; logic [31:0] alu, pc4, word;
        int delay;
        for (int n = 0; n < 60; n++) begin
            rw    = 1'($urandom);
            rd    = 5'($urandom);
            src   = 2'($urandom);
            alu   = $urandom;
            pc4   = $urandom;
            size  = 2'($urandom);
            uns   = 1'($urandom);
            addr  = 2'($urandom);
            word  = $urandom;
            noise = 1'($urandom);
            delay = int'($urandom_range(1, LT + 2));
            model_expect(rw, rd, src, alu, pc4, size, uns, addr, word, delay, e_we, e_rd, e_data, e_to);
            issue(rw, rd, src, alu, pc4, size, uns, addr, word, delay, noise, we, wr, wd, to, ret, rdy, wb);
            total++;
            if (we !== e_we || wr !== e_rd || wd !== e_data || to !== e_to || ret !== exp_retire || wb !== 0) begin
                bad++; $display("FAIL rand_%0d got=%0b/%0d/%08h/%0b/%0d/%0d want=%0b/%0d/%08h/%0b/%0d/0",
                                n, we, wr, wd, to, ret, wb, e_we, e_rd, e_data, e_to, exp_retire);
            end
            if ($urandom_range(0, 1) == 1) begin
                tick();
                total++;
                if (RegWrite !== 1'b0 || Write_register !== 5'd0 || Write_data !== 32'd0 || load_timeout !== 1'b0) begin
                    bad++; $display("FAIL rand_idle_%0d got=%0b/%0d/%08h/%0b want=0/0/0/0", n, RegWrite, Write_register, Write_data, load_timeout);
                end
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_load();
        in_valid          = 1'b1;
        in_RegWrite       = 1'b1;
        in_Write_register = 5'd7;
        in_MemtoReg       = 2'b01;
        in_load_size      = 2'd2;
        tick();
        in_valid = 1'b0;
        tick();
        total++; if (wb_stall !== 1'b1) begin bad++; $display("FAIL midload_stall got=%0b want=1", wb_stall); end
        reset       = 1'b1;
        rdata_valid = 1'b1;
        rdata       = 32'h55AA55AA;
        tick();
        rdata_valid = 1'b0;
        reset       = 1'b0;
        exp_retire  = 32'd0;
        total++;
        if (RegWrite !== 1'b0 || Write_register !== 5'd0 || Write_data !== 32'd0 || retire_count !== 32'd0 || wb_stall !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL midload_reset got=%0b/%0d/%08h/%0d/%0b/%0b want=0/0/0/0/0/1",
                            RegWrite, Write_register, Write_data, retire_count, wb_stall, in_ready);
        end
        tick();
        total++; if (RegWrite !== 1'b0 || retire_count !== 32'd0) begin bad++; $display("FAIL midload_after got=%0b/%0d want=0/0", RegWrite, retire_count); end
        $display("txn reset during load");
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_reg_zero();
        test_byte_load();
        test_half_load();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final pipeline stage of the CPU, i.e. the writer side of the register file's write port.
- Accepts retiring instructions from the MEM stage and waits for variable-latency load data from data memory.
- Selects and extends the result, then drives the one-cycle RegWrite/Write_register/Write_data commit into the register file.
- Asserts a stall toward earlier stages while a load is outstanding, and counts retired instructions.

Parameters:
- LOAD_TIMEOUT, 16, max cycles spent in WAIT_LOAD before abandoning the load (min 1)
- CNT_W, 32, width of the retire counter

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  unit can accept this cycle
- in_RegWrite  in  1  instruction writes a register
- in_Write_register  in  5  destination register
- in_MemtoReg  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 reserved (treated as 00)
- in_ALU_out  in  32  ALU result
- in_PC_plus4  in  32  link value
- in_load_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- in_load_unsigned  in  1  1 = zero-extend, 0 = sign-extend
- in_addr_low  in  2  load address bits [1:0]
- rdata_valid  in  1  load data valid (single-cycle pulse)
- rdata  in  32  raw memory word, little-endian lanes
- RegWrite  out  1  register file write enable
- Write_register  out  5  register file write address
- Write_data  out  32  register file write data
- wb_stall  out  1  high while a load is outstanding
- load_timeout  out  1  one-cycle pulse when a load is abandoned
- retire_count  out  CNT_W  committed-instruction count

Behaviour:
- Reset (sync):
  - state=IDLE, in_ready=1.
  - RegWrite=0, Write_register=0, Write_data=0.
  - wb_stall=0, load_timeout=0, retire_count=0, timeout counter=0.
  - Reset mid-load discards the pending load with no commit.
- States: IDLE, COMMIT, WAIT_LOAD.
- Acceptance:
  - Handshake is in_valid && in_ready.
  - in_ready = (state != WAIT_LOAD); combinational from state only.
  - Payload is captured into a holding register at accept.
- Non-load accepted (MemtoReg != 01) at cycle t:
  - Commit at t+1 (state COMMIT).
  - Back-to-back accepts give one commit per cycle.
- Load accepted at t:
  - Go to WAIT_LOAD at t+1; wb_stall=1 throughout WAIT_LOAD.
  - First cycle in WAIT_LOAD with rdata_valid=1, at cycle u: extract and extend rdata into the holding register.
  - Commit at u+1 (COMMIT). Minimum load latency, accept to commit, is 2 cycles.
- rdata_valid outside WAIT_LOAD is ignored. rdata_valid arriving in the accept cycle is ignored.
- Load extraction:
  - byte = rdata[8*a+7:8*a].
  - half = rdata[16*a[1]+15:16*a[1]]; a[0] is ignored for half.
  - word = rdata; addr_low is ignored for word.
  - Extension per in_load_unsigned.
- Timeout:
  - Counter increments each cycle in WAIT_LOAD.
  - If LOAD_TIMEOUT cycles elapse without rdata_valid: pulse load_timeout for 1 cycle, commit with RegWrite forced 0, return to IDLE/accept path.
  - Counter clears on leaving WAIT_LOAD.
- Commit cycle (exactly one cycle per instruction):
  - RegWrite = held RegWrite && (held Write_register != 0).
  - retire_count increments by 1, including when RegWrite=0 or on timeout. It wraps modulo 2^CNT_W.
- Write-port idle rule:
  - The register file bypasses Write_data to any reader whose address matches Write_register, regardless of RegWrite.
  - Therefore Write_register must be driven 0 and Write_data 0 in every cycle where RegWrite=0.
  - Write-port outputs are registered.
- Transitions:
  - IDLE/COMMIT → COMMIT on accept of a non-load.
  - IDLE/COMMIT → WAIT_LOAD on accept of a load.
  - IDLE/COMMIT → IDLE with no accept.
  - WAIT_LOAD → COMMIT on rdata_valid or timeout.
  - WAIT_LOAD → WAIT_LOAD otherwise.
- Commit and a new accept occur in the same cycle without conflict. The holding register is reloaded on the same edge that presents the commit.

Decomposition:
- Shared package holds:
  - MemtoReg codes (WB_SRC_ALU=2'b00, WB_SRC_MEM=2'b01, WB_SRC_PC4=2'b10).
  - Load size codes (LD_BYTE, LD_HALF, LD_WORD).
  - State encoding for IDLE/COMMIT/WAIT_LOAD.
- One sub-module: load_extender, purely combinational: rdata, addr_low, size, unsigned → 32-bit result.

Test Plan:
- ALU write: accept in_RegWrite=1, reg=5, MemtoReg=00, ALU_out=0x1234 at t → at t+1 RegWrite=1, Write_register=5, Write_data=0x1234. At t+2 all three are 0; retire_count=1.
- Register zero and idle rule: accept RegWrite=1, reg=0, ALU_out=0xFFFF → commit cycle RegWrite=0, Write_register=0, Write_data=0; retire_count increments.
- Signed byte load: load reg=8, byte, signed, addr_low=2; rdata_valid with rdata=0x12F03456 three cycles after accept → wb_stall=1 and in_ready=0 while waiting; next cycle Write_data=0xFFFFFFF0, Write_register=8.
- Half load unsigned: addr_low=2, rdata=0x8001ABCD → Write_data=0x00008001. With signed extension → 0xFFFF8001.
- Timeout: load accepted, no rdata_valid for 16 cycles → load_timeout pulses once, RegWrite stays 0, retire_count+1, in_ready returns to 1. A late rdata_valid afterwards has no effect.
- Back-to-back and reset: three non-loads on consecutive cycles → three consecutive commits in order. Reset asserted during WAIT_LOAD → next cycle all outputs 0, retire_count=0, no commit.
